layer_engine_dispatcher: RTL and testbench

LAYER_ENGINE_DISPATCHER -- requirements
Module: layer_engine_dispatcher

---
 rtl/layer_engine_dispatcher_pkg.sv | 44 ++++
 rtl/layer_engine_dispatcher_opcode_port_slot.sv | 35 +++
 rtl/layer_engine_dispatcher.sv | 244 ++++++++++++++++++++++++
 tb/tb_layer_engine_dispatcher.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_engine_dispatcher_pkg.sv
// Shared constants, header layout and FSM state type for layer_engine_dispatcher.
package layer_engine_dispatcher_pkg;

  localparam logic [3:0] MSG_OPCODE  = 4'd1;
  localparam logic [3:0] MSG_CFG_WR  = 4'd2;
  localparam logic [3:0] MSG_CFG_RD  = 4'd3;

  localparam logic [3:0] RSP_RD_DATA = 4'd8;
  localparam logic [3:0] RSP_WR_ACK  = 4'd9;
  localparam logic [3:0] RSP_ERR     = 4'd14;

  localparam logic [7:0] ERR_NONE     = 8'd0;
  localparam logic [7:0] ERR_BAD_TYPE = 8'd1;
  localparam logic [7:0] ERR_BAD_PORT = 8'd2;
  localparam logic [7:0] ERR_TIMEOUT  = 8'd3;

  localparam int unsigned HDR_TYPE_LSB = 0;
  localparam int unsigned HDR_TYPE_W   = 4;
  localparam int unsigned HDR_PORT_LSB = 4;
  localparam int unsigned HDR_PORT_W   = 8;
  localparam int unsigned HDR_ADDR_LSB = 16;
  localparam int unsigned HDR_ADDR_W   = 16;
  localparam int unsigned HDR_DATA_LSB = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CFG_WR,
    ST_CFG_RD,
    ST_RESP
  } state_e;

  // The response header reuses the port field position for the error code.
  function automatic logic [31:0] make_header(input logic [3:0]  t,
                                              input logic [7:0]  code,
                                              input logic [15:0] addr);
    logic [31:0] h;
    h = '0;
    h[HDR_TYPE_LSB +: HDR_TYPE_W] = t;
    h[HDR_PORT_LSB +: HDR_PORT_W] = code;
    h[HDR_ADDR_LSB +: HDR_ADDR_W] = addr;
    return h;
  endfunction

endpackage

// File: rtl/layer_engine_dispatcher_opcode_port_slot.sv
// One-deep opcode holding register with valid/accept handshake for one engine port.
module opcode_port_slot #(
  parameter int unsigned C_OPCODE_WIDTH = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_load,
  input  logic [C_OPCODE_WIDTH-1:0] i_opcode,
  input  logic                      i_accept,
  output logic                      o_valid,
  output logic [C_OPCODE_WIDTH-1:0] o_opcode,
  output logic                      o_ready
);

  logic                      r_valid;
  logic [C_OPCODE_WIDTH-1:0] r_opcode;

  // A load in the same cycle as a drain replaces the old entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid  <= 1'b0;
      r_opcode <= '0;
    end else if (i_load) begin
      r_valid  <= 1'b1;
      r_opcode <= i_opcode;
    end else if (r_valid && i_accept) begin
      r_valid  <= 1'b0;
    end
  end

  assign o_valid  = r_valid;
  assign o_opcode = r_opcode;
  assign o_ready  = !r_valid || i_accept;

endmodule

// File: rtl/layer_engine_dispatcher.sv
// Routes inbound messages to per-port opcode slots or the config bus and returns responses.
// Optional ack watchdog enabled by defining LAYER_ENGINE_DISPATCH_TIMEOUT_EN.
module layer_engine_dispatcher
  import layer_engine_dispatcher_pkg::*;
#(
  parameter int unsigned C_DATA_WIDTH       = 256,
  parameter int unsigned C_NUM_OPCODE_PORTS = 4,
  parameter int unsigned C_OPCODE_WIDTH     = 64,
  parameter int unsigned C_CFG_ADDR_WIDTH   = 16,
  parameter int unsigned C_CFG_DATA_WIDTH   = 128,
  parameter int unsigned C_TIMEOUT_CYCLES   = 1024
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         msg_in_valid,
  output logic                                         msg_in_accept,
  input  logic [C_DATA_WIDTH-1:0]                      msg_in_payload,
  output logic                                         msg_out_valid,
  input  logic                                         msg_out_accept,
  output logic [C_DATA_WIDTH-1:0]                      msg_out_payload,
  output logic [C_NUM_OPCODE_PORTS*C_OPCODE_WIDTH-1:0] opcode,
  output logic [C_NUM_OPCODE_PORTS-1:0]                opcode_valid,
  input  logic [C_NUM_OPCODE_PORTS-1:0]                opcode_accept,
  output logic [C_CFG_ADDR_WIDTH-1:0]                  config_address,
  output logic                                         config_wren,
  input  logic                                         config_wrack,
  output logic                                         config_rden,
  input  logic                                         config_rdack,
  output logic [C_CFG_DATA_WIDTH-1:0]                  config_datain,
  input  logic [C_CFG_DATA_WIDTH-1:0]                  config_dataout
);

  localparam logic [7:0]  LP_NPORTS  = 8'(C_NUM_OPCODE_PORTS);
  localparam int unsigned LP_USED_W  = HDR_DATA_LSB +
      ((C_OPCODE_WIDTH > C_CFG_DATA_WIDTH) ? C_OPCODE_WIDTH : C_CFG_DATA_WIDTH);

  state_e                            r_state;
  state_e                            w_state_nxt;
  logic                              r_ready;
  logic [HDR_ADDR_W-1:0]             r_addr;
  logic [C_CFG_DATA_WIDTH-1:0]       r_data;
  logic [C_DATA_WIDTH-1:0]           r_resp;

  logic [3:0]                        w_type;
  logic [7:0]                        w_port;
  logic [HDR_ADDR_W-1:0]             w_addr;
  logic [C_CFG_DATA_WIDTH-1:0]       w_data;
  logic [C_OPCODE_WIDTH-1:0]         w_opcode;
  logic [C_NUM_OPCODE_PORTS-1:0]     w_slot_ready;
  logic [15:0]                       w_ready_vec;

  logic                              w_in_accept;
  logic                              w_load_opc;
  logic                              w_ld_cmd;
  logic                              w_ld_resp;
  logic                              w_wren;
  logic                              w_rden;
  logic                              w_out_valid;
  logic [3:0]                        w_resp_type;
  logic [7:0]                        w_resp_code;
  logic [HDR_ADDR_W-1:0]             w_resp_addr;
  logic [C_CFG_DATA_WIDTH-1:0]       w_resp_data;
  logic [C_DATA_WIDTH-1:0]           w_resp_full;
  logic                              w_unused;

  assign w_type      = msg_in_payload[HDR_TYPE_LSB +: HDR_TYPE_W];
  assign w_port      = msg_in_payload[HDR_PORT_LSB +: HDR_PORT_W];
  assign w_addr      = msg_in_payload[HDR_ADDR_LSB +: HDR_ADDR_W];
  assign w_data      = msg_in_payload[HDR_DATA_LSB +: C_CFG_DATA_WIDTH];
  assign w_opcode    = msg_in_payload[HDR_DATA_LSB +: C_OPCODE_WIDTH];
  assign w_ready_vec = 16'(w_slot_ready);

  if (C_DATA_WIDTH > LP_USED_W) begin : g_unused_hi
    assign w_unused = ^{msg_in_payload[C_DATA_WIDTH-1:LP_USED_W], msg_in_payload[15:12]};
  end else begin : g_unused_lo
    assign w_unused = ^msg_in_payload[15:12];
  end

`ifdef LAYER_ENGINE_DISPATCH_TIMEOUT_EN
  localparam int unsigned          LP_CNT_W    = $clog2(C_TIMEOUT_CYCLES + 1);
  localparam logic [LP_CNT_W-1:0]  LP_CNT_LAST = LP_CNT_W'(C_TIMEOUT_CYCLES - 1);
  logic [LP_CNT_W-1:0]             r_wait_cnt;

  // Counts cycles spent waiting on the current config ack; cleared outside the wait states.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait_cnt <= '0;
    end else if (r_state == ST_CFG_WR || r_state == ST_CFG_RD) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_accept = 1'b0;
    w_load_opc  = 1'b0;
    w_ld_cmd    = 1'b0;
    w_ld_resp   = 1'b0;
    w_wren      = 1'b0;
    w_rden      = 1'b0;
    w_out_valid = 1'b0;
    w_resp_type = RSP_ERR;
    w_resp_code = ERR_NONE;
    w_resp_addr = w_addr;
    w_resp_data = '0;
    case (r_state)
      ST_IDLE: begin
        if (r_ready && msg_in_valid) begin
          case (w_type)
            MSG_OPCODE: begin
              if (w_port >= LP_NPORTS) begin
                w_in_accept = 1'b1;
                w_ld_resp   = 1'b1;
                w_resp_code = ERR_BAD_PORT;
                w_state_nxt = ST_RESP;
              end else if (w_ready_vec[w_port[3:0]]) begin
                w_in_accept = 1'b1;
                w_load_opc  = 1'b1;
              end
            end
            MSG_CFG_WR: begin
              w_in_accept = 1'b1;
              w_ld_cmd    = 1'b1;
              w_state_nxt = ST_CFG_WR;
            end
            MSG_CFG_RD: begin
              w_in_accept = 1'b1;
              w_ld_cmd    = 1'b1;
              w_state_nxt = ST_CFG_RD;
            end
            default: begin
              w_in_accept = 1'b1;
              w_ld_resp   = 1'b1;
              w_resp_code = ERR_BAD_TYPE;
              w_state_nxt = ST_RESP;
            end
          endcase
        end
      end
      ST_CFG_WR: begin
        w_wren      = 1'b1;
        w_resp_addr = r_addr;
        if (config_wrack) begin
          w_ld_resp   = 1'b1;
          w_resp_type = RSP_WR_ACK;
          w_state_nxt = ST_RESP;
        end
`ifdef LAYER_ENGINE_DISPATCH_TIMEOUT_EN
        else if (r_wait_cnt == LP_CNT_LAST) begin
          w_ld_resp   = 1'b1;
          w_resp_code = ERR_TIMEOUT;
          w_state_nxt = ST_RESP;
        end
`endif
      end
      ST_CFG_RD: begin
        w_rden      = 1'b1;
        w_resp_addr = r_addr;
        if (config_rdack) begin
          w_ld_resp   = 1'b1;
          w_resp_type = RSP_RD_DATA;
          w_resp_data = config_dataout;
          w_state_nxt = ST_RESP;
        end
`ifdef LAYER_ENGINE_DISPATCH_TIMEOUT_EN
        else if (r_wait_cnt == LP_CNT_LAST) begin
          w_ld_resp   = 1'b1;
          w_resp_code = ERR_TIMEOUT;
          w_state_nxt = ST_RESP;
        end
`endif
      end
      ST_RESP: begin
        w_out_valid = 1'b1;
        if (msg_out_accept) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_resp_full = '0;
    w_resp_full[31:0] = make_header(w_resp_type, w_resp_code, w_resp_addr);
    w_resp_full[HDR_DATA_LSB +: C_CFG_DATA_WIDTH] = w_resp_data;
  end

  // r_ready holds off acceptance until the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ready <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
      r_resp  <= '0;
    end else begin
      r_ready <= 1'b1;
      if (w_ld_cmd) begin
        r_addr <= w_addr;
        r_data <= w_data;
      end
      if (w_ld_resp) begin
        r_resp <= w_resp_full;
      end
    end
  end

  for (genvar p = 0; p < C_NUM_OPCODE_PORTS; p++) begin : g_slot
    opcode_port_slot #(
      .C_OPCODE_WIDTH(C_OPCODE_WIDTH)
    ) u_slot (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load_opc && (w_port == 8'(p))),
      .i_opcode(w_opcode),
      .i_accept(opcode_accept[p]),
      .o_valid (opcode_valid[p]),
      .o_opcode(opcode[p*C_OPCODE_WIDTH +: C_OPCODE_WIDTH]),
      .o_ready (w_slot_ready[p])
    );
  end

  assign msg_in_accept   = w_in_accept;
  assign msg_out_valid   = w_out_valid;
  assign msg_out_payload = r_resp;
  assign config_wren     = w_wren;
  assign config_rden     = w_rden;
  assign config_address  = r_addr[C_CFG_ADDR_WIDTH-1:0];
  assign config_datain   = r_data;

endmodule

// File: tb/tb_layer_engine_dispatcher.sv
// Directed and randomized self-checking bench for layer_engine_dispatcher.
module tb_layer_engine_dispatcher;

  localparam int unsigned DW = 256;
  localparam int unsigned NP = 4;
  localparam int unsigned OW = 64;
  localparam int unsigned AW = 16;
  localparam int unsigned CW = 128;
  localparam int unsigned TO = 1024;

  logic              clk = 1'b0;
  logic              rst;
  logic              msg_in_valid;
  logic              msg_in_accept;
  logic [DW-1:0]     msg_in_payload;
  logic              msg_out_valid;
  logic              msg_out_accept;
  logic [DW-1:0]     msg_out_payload;
  logic [NP*OW-1:0]  opcode;
  logic [NP-1:0]     opcode_valid;
  logic [NP-1:0]     opcode_accept;
  logic [AW-1:0]     config_address;
  logic              config_wren;
  logic              config_wrack;
  logic              config_rden;
  logic              config_rdack;
  logic [CW-1:0]     config_datain;
  logic [CW-1:0]     config_dataout;

  int n_pass  = 0;
  int n_total = 0;

  layer_engine_dispatcher #(
    .C_DATA_WIDTH      (DW),
    .C_NUM_OPCODE_PORTS(NP),
    .C_OPCODE_WIDTH    (OW),
    .C_CFG_ADDR_WIDTH  (AW),
    .C_CFG_DATA_WIDTH  (CW),
    .C_TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .msg_in_valid   (msg_in_valid),
    .msg_in_accept  (msg_in_accept),
    .msg_in_payload (msg_in_payload),
    .msg_out_valid  (msg_out_valid),
    .msg_out_accept (msg_out_accept),
    .msg_out_payload(msg_out_payload),
    .opcode         (opcode),
    .opcode_valid   (opcode_valid),
    .opcode_accept  (opcode_accept),
    .config_address (config_address),
    .config_wren    (config_wren),
    .config_wrack   (config_wrack),
    .config_rden    (config_rden),
    .config_rdack   (config_rdack),
    .config_datain  (config_datain),
    .config_dataout (config_dataout)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Messages and responses share the layout: type, port/code, addr, data.
  function automatic logic [DW-1:0] mk_word(input logic [3:0] t, input logic [7:0] f,
                                             input logic [15:0] a, input logic [CW-1:0] d);
    logic [DW-1:0] r;
    r = '0;
    r[3:0]   = t;
    r[11:4]  = f;
    r[31:16] = a;
    r[32 +: CW] = d;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one message and returns the cycles waited (-1 if never accepted).
  task automatic send_msg(input logic [DW-1:0] pl, output int waits);
    logic acc;
    msg_in_valid   = 1'b1;
    msg_in_payload = pl;
    waits = -1;
    for (int i = 0; i < 200; i++) begin
      #4;
      acc = msg_in_accept;
      step();
      if (acc) begin
        msg_in_valid = 1'b0;
        waits = i;
        return;
      end
    end
    msg_in_valid = 1'b0;
  endtask

  initial begin
    int            w;
    int            nw;
    logic [DW-1:0] pl;
    logic [DW-1:0] exp_resp;
    logic [OW-1:0] exp_op [NP];
    bit            exp_pend [NP];
    logic [NP-1:0] exp_vec;
    bit            resp_pend;
    bit            busy;
    bit            exp_acc;
    bit            consumed;
    int            cfg_wait;
    int            ack_dly;
    int            n_msgs;
    logic [15:0]   cur_addr;
    logic [CW-1:0] cur_data;
    logic [3:0]    t;
    logic [7:0]    pt;

    rst = 1'b0;
    msg_in_valid = 1'b0;
    msg_in_payload = '0;
    msg_out_accept = 1'b0;
    opcode_accept = '0;
    config_wrack = 1'b0;
    config_rdack = 1'b0;
    config_dataout = '0;

    // Reset state, with an inbound message already offered
    msg_in_valid   = 1'b1;
    msg_in_payload = mk_word(4'd1, 8'd0, 16'h0, 128'h77);
    step();
    step();
    chk("rst_in_accept", msg_in_accept, 0);
    chk("rst_opv", opcode_valid, 0);
    chk("rst_out_valid", msg_out_valid, 0);
    chk("rst_out_payload", msg_out_payload, 0);
    chk("rst_wren", config_wren, 0);
    chk("rst_rden", config_rden, 0);
    chk("rst_addr", config_address, 0);
    #2;
    rst = 1'b1;
    #1;
    chk("pre_edge_accept", msg_in_accept, 0);
    msg_in_valid = 1'b0;
    step();
    step();

    // Opcode to port 2
    send_msg(mk_word(4'd1, 8'd2, 16'h0, 128'hDEAD_BEEF), w);
    chk("op2_wait", w, 0);
    chk("op2_valid", opcode_valid, 4'b0100);
    chk("op2_value", opcode[2*OW +: OW], 64'hDEAD_BEEF);
    opcode_accept[2] = 1'b1;
    step();
    opcode_accept = '0;
    chk("op2_clear", opcode_valid, 0);

    // Back-pressure on port 1 while port 0 still accepted
    send_msg(mk_word(4'd1, 8'd1, 16'h0, 128'h1111), w);
    chk("p1a_wait", w, 0);
    send_msg(mk_word(4'd1, 8'd0, 16'h0, 128'h0A0A), w);
    chk("p0_wait", w, 0);
    chk("p0p1_valid", opcode_valid, 4'b0011);
    msg_in_valid   = 1'b1;
    msg_in_payload = mk_word(4'd1, 8'd1, 16'h0, 128'h2222);
    for (int i = 0; i < 3; i++) begin
      #4;
      chk("p1b_held", msg_in_accept, 0);
      step();
    end
    chk("p1a_stable", opcode[1*OW +: OW], 64'h1111);
    opcode_accept[1] = 1'b1;
    #4;
    chk("p1b_drain_accept", msg_in_accept, 1);
    step();
    msg_in_valid  = 1'b0;
    opcode_accept = '0;
    chk("p1b_value", opcode[1*OW +: OW], 64'h2222);
    chk("p1b_valid", opcode_valid, 4'b0011);
    opcode_accept = 4'b0011;
    step();
    opcode_accept = '0;
    chk("p01_drained", opcode_valid, 0);

    // Config write with ack on the fifth wren cycle
    send_msg(mk_word(4'd2, 8'd0, 16'h0010, 128'h1234), w);
    chk("wr_wait", w, 0);
    chk("wr_addr", config_address, 16'h0010);
    chk("wr_data", config_datain, 128'h1234);
    chk("wr_in_block", msg_in_accept, 0);
    nw = 0;
    for (int i = 0; i < 20; i++) begin
      if (!config_wren) break;
      nw++;
      if (nw == 5) config_wrack = 1'b1;
      step();
      config_wrack = 1'b0;
    end
    chk("wr_len", nw, 5);
    chk("wr_resp_valid", msg_out_valid, 1);
    chk("wr_resp", msg_out_payload, mk_word(4'd9, 8'd0, 16'h0010, '0));
    msg_out_accept = 1'b1;
    step();
    msg_out_accept = 1'b0;
    chk("wr_resp_done", msg_out_valid, 0);

    // Config read, response held under back-pressure
    send_msg(mk_word(4'd3, 8'd0, 16'h0020, '0), w);
    chk("rd_en", config_rden, 1);
    chk("rd_addr", config_address, 16'h0020);
    config_dataout = 128'hCAFE;
    config_rdack   = 1'b1;
    step();
    config_rdack   = 1'b0;
    config_dataout = 128'hFFFF;
    chk("rd_en_drop", config_rden, 0);
    msg_in_valid   = 1'b1;
    msg_in_payload = mk_word(4'd1, 8'd3, 16'h0, 128'h33);
    for (int i = 0; i < 3; i++) begin
      chk("rd_resp_valid", msg_out_valid, 1);
      chk("rd_resp_hold", msg_out_payload, mk_word(4'd8, 8'd0, 16'h0020, 128'hCAFE));
      #4;
      chk("resp_in_block", msg_in_accept, 0);
      step();
    end
    msg_out_accept = 1'b1;
    #4;
    chk("resp_acc_in_block", msg_in_accept, 0);
    step();
    msg_out_accept = 1'b0;
    chk("rd_resp_done", msg_out_valid, 0);
    #4;
    chk("idle_accept_again", msg_in_accept, 1);
    step();
    msg_in_valid = 1'b0;
    chk("p3_valid", opcode_valid, 4'b1000);

    // Illegal type, then out-of-range port
    send_msg(mk_word(4'd7, 8'd0, 16'h0077, '0), w);
    chk("err1_wait", w, 0);
    chk("err1_valid", msg_out_valid, 1);
    chk("err1_resp", msg_out_payload, mk_word(4'd14, 8'd1, 16'h0077, '0));
    msg_out_accept = 1'b1;
    step();
    msg_out_accept = 1'b0;
    send_msg(mk_word(4'd1, 8'd9, 16'h0099, 128'h5), w);
    chk("err2_wait", w, 0);
    chk("err2_resp", msg_out_payload, mk_word(4'd14, 8'd2, 16'h0099, '0));
    msg_out_accept = 1'b1;
    step();
    msg_out_accept = 1'b0;
    chk("err2_done", msg_out_valid, 0);

`ifdef LAYER_ENGINE_DISPATCH_TIMEOUT_EN
    send_msg(mk_word(4'd2, 8'd0, 16'h0055, 128'h5), w);
    nw = 0;
    for (int i = 0; i < 1100; i++) begin
      if (!config_wren) break;
      nw++;
      step();
    end
    chk("to_len", nw, TO);
    chk("to_resp", msg_out_payload, mk_word(4'd14, 8'd3, 16'h0055, '0));
    msg_out_accept = 1'b1;
    step();
    msg_out_accept = 1'b0;
`endif

    // Reset in the middle of a config read with an opcode pending on port 3
    send_msg(mk_word(4'd3, 8'd0, 16'h0042, '0), w);
    step();
    step();
    chk("mid_rden", config_rden, 1);
    msg_in_valid   = 1'b1;
    msg_in_payload = mk_word(4'd1, 8'd0, 16'h0, 128'h44);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_rden", config_rden, 0);
    chk("mid_rst_accept", msg_in_accept, 0);
    chk("mid_rst_opv", opcode_valid, 0);
    chk("mid_rst_addr", config_address, 0);
    chk("mid_rst_out_valid", msg_out_valid, 0);
    msg_in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    step();
    step();
    send_msg(mk_word(4'd1, 8'd0, 16'h0, 128'h55), w);
    chk("post_rst_wait", w, 0);
    chk("post_rst_opv", opcode_valid, 4'b0001);
    chk("post_rst_val", opcode[OW-1:0], 64'h55);
    opcode_accept = 4'b0001;
    step();
    opcode_accept = '0;

    // Randomized traffic against a transaction-level model
    for (int p = 0; p < NP; p++) begin
      exp_pend[p] = 1'b0;
      exp_op[p]   = '0;
    end
    resp_pend = 1'b0;
    exp_resp  = '0;
    cfg_wait  = 0;
    consumed  = 1'b0;
    ack_dly   = 0;
    n_msgs    = 0;
    cur_addr  = '0;
    cur_data  = '0;
    for (int cyc = 0; cyc < 6000 && n_msgs < 300; cyc++) begin
      opcode_accept  = NP'($urandom);
      msg_out_accept = 1'($urandom);
      config_dataout = {$urandom, $urandom, $urandom, $urandom};
      if (config_wren || config_rden) begin
        config_wrack = config_wren && (ack_dly == 0);
        config_rdack = config_rden && (ack_dly == 0);
        if (ack_dly > 0) ack_dly--;
      end else begin
        config_wrack = 1'b0;
        config_rdack = 1'b0;
        ack_dly = $urandom_range(0, 4);
      end
      if (consumed) begin
        msg_in_valid = 1'b0;
        consumed = 1'b0;
      end
      if (!msg_in_valid && $urandom_range(0, 3) != 0) begin
        for (int k = 0; k < DW / 32; k++) pl[k*32 +: 32] = $urandom;
        case ($urandom_range(0, 7))
          0, 1, 2: begin t = 4'd1; pt = 8'($urandom_range(0, NP - 1)); end
          3:       begin t = 4'd1; pt = 8'($urandom_range(NP, 255)); end
          4:       begin t = 4'd2; pt = 8'($urandom); end
          5:       begin t = 4'd3; pt = 8'($urandom); end
          default: begin t = 4'($urandom_range(4, 16)); pt = 8'($urandom); end
        endcase
        pl[3:0]  = t;
        pl[11:4] = pt;
        msg_in_valid   = 1'b1;
        msg_in_payload = pl;
      end
      #4;
      t  = msg_in_payload[3:0];
      pt = msg_in_payload[11:4];
      busy = resp_pend || (cfg_wait != 0);
      if (busy) exp_acc = 1'b0;
      else if (t == 4'd1 && pt < NP) exp_acc = !exp_pend[pt] || opcode_accept[pt];
      else exp_acc = 1'b1;
      if (msg_in_valid) chk("rnd_accept", msg_in_accept, exp_acc);
      chk("rnd_wren", config_wren, cfg_wait == 2);
      chk("rnd_rden", config_rden, cfg_wait == 3);
      for (int p = 0; p < NP; p++) exp_vec[p] = exp_pend[p];
      chk("rnd_opv", opcode_valid, exp_vec);
      for (int p = 0; p < NP; p++)
        if (exp_pend[p]) chk("rnd_opcode", opcode[p*OW +: OW], exp_op[p]);
      chk("rnd_out_valid", msg_out_valid, resp_pend);
      if (resp_pend) chk("rnd_resp", msg_out_payload, exp_resp);

      for (int p = 0; p < NP; p++)
        if (exp_pend[p] && opcode_accept[p]) exp_pend[p] = 1'b0;
      if (resp_pend && msg_out_accept) begin
        resp_pend = 1'b0;
        n_msgs++;
      end
      if (cfg_wait == 2 && config_wrack) begin
        chk("rnd_wr_addr", config_address, cur_addr);
        chk("rnd_wr_data", config_datain, cur_data);
        exp_resp  = mk_word(4'd9, 8'd0, cur_addr, '0);
        resp_pend = 1'b1;
        cfg_wait  = 0;
      end
      if (cfg_wait == 3 && config_rdack) begin
        chk("rnd_rd_addr", config_address, cur_addr);
        exp_resp  = mk_word(4'd8, 8'd0, cur_addr, config_dataout);
        resp_pend = 1'b1;
        cfg_wait  = 0;
      end
      if (msg_in_valid && msg_in_accept) begin
        consumed = 1'b1;
        cur_addr = msg_in_payload[31:16];
        cur_data = msg_in_payload[32 +: CW];
        if (t == 4'd1 && pt < NP) begin
          exp_pend[pt] = 1'b1;
          exp_op[pt]   = msg_in_payload[32 +: OW];
          n_msgs++;
        end else if (t == 4'd1) begin
          exp_resp  = mk_word(4'd14, 8'd2, cur_addr, '0);
          resp_pend = 1'b1;
        end else if (t == 4'd2) begin
          cfg_wait = 2;
        end else if (t == 4'd3) begin
          cfg_wait = 3;
        end else begin
          exp_resp  = mk_word(4'd14, 8'd1, cur_addr, '0);
          resp_pend = 1'b1;
        end
      end
      step();
    end
    chk("rnd_progress", n_msgs >= 300, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
